// File: rtl/rfphoenix_issue_ctrl_pkg.sv
// Shared types and sizes for the rfPhoenix issue controller.
//   NREG / NTAG  : register-file depth and number of in-flight multicycle tags
//   RW / TW      : register-index and tag widths
//   iss_state_e  : issue sequencer states
//   tag_ent_t    : per-tag record of what a multicycle op will retire
//   reg_haz()    : pending-bit lookup for one register operand
package rfphoenix_issue_ctrl_pkg;

  localparam int NREG = 64;
  localparam int NTAG = 4;
  localparam int RW   = $clog2(NREG);
  localparam int TW   = $clog2(NTAG);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    SERIAL = 2'd2
  } iss_state_e;

  // wr marks entries that actually own a pending bit.
  // Writes to r0 under rz own no pending bit, so completion must not clear anything.
  typedef struct packed {
    logic          valid;
    logic          wr;
    logic          vec;
    logic [RW-1:0] idx;
    logic          mem;
  } tag_ent_t;

  // Scalar r0 is exempt when it is hardwired to zero.
  function automatic logic reg_haz(input logic [RW-1:0]   idx,
                                   input logic            vec,
                                   input logic            rz,
                                   input logic [NREG-1:0] sb_s,
                                   input logic [NREG-1:0] sb_v);
    logic h;
    if (vec)
      h = sb_v[idx];
    else if (rz && (idx == '0))
      h = 1'b0;
    else
      h = sb_s[idx];
    return h;
  endfunction

endpackage

// File: rtl/rfphoenix_issue_ctrl_tag_pool.sv
// Tag pool for in-flight multicycle ops.
//   clk, rst_n  : clock, async active-low reset
//   alloc       : take alloc_tag this cycle
//   rel/rel_tag : return a tag
//   avail       : at least one tag free
//   alloc_tag   : lowest-numbered free tag
//   any_busy    : at least one tag outstanding
module rfphoenix_issue_ctrl_tag_pool
  import rfphoenix_issue_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc,
  input  logic          rel,
  input  logic [TW-1:0] rel_tag,
  output logic          avail,
  output logic [TW-1:0] alloc_tag,
  output logic          any_busy
);

  logic [NTAG-1:0] busy_map;

  // Find-first-free works only from the registered map.
  // A tag released this cycle is therefore offered no earlier than next cycle.
  always_comb begin
    avail     = 1'b0;
    alloc_tag = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (!busy_map[i]) begin
        avail     = 1'b1;
        alloc_tag = TW'(i);
      end
    end
  end

  assign any_busy = |busy_map;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_map <= '0;
    end else begin
      if (rel)
        busy_map[rel_tag] <= 1'b0;
      if (alloc)
        busy_map[alloc_tag] <= 1'b1;
    end
  end

endmodule

// File: rtl/rfphoenix_issue_ctrl.sv
// Issue sequencer between decode and execute.
// Tracks pending scalar and vector destinations of in-flight multicycle ops.
// Holds decode on RAW/WAW hazards, a busy memory port, tag exhaustion or CSR serialisation.
// Feeds execute through a one-entry registered issue stage.
//   clk, rst_n                : clock, async active-low reset
//   flush                     : drop the issue-stage entry (scoreboard kept)
//   rz                        : scalar r0 reads as zero
//   dec_v / dec_rdy           : decode handshake
//   ra, rb, rc, rt / ta..tt   : operand indices and vector-file selects
//   rfwr, vrfwr               : destination write enables
//   mc, mem, csr              : multicycle / load-store / serialising op
//   iss_v, iss_rdy, iss_tag   : issue-stage handshake and tag
//   cmp_v, cmp_tag            : multicycle completion
//   busy                      : any tag outstanding
//   stall_cnt                 : saturating count of stalled decode cycles
module rfphoenix_issue_ctrl
  import rfphoenix_issue_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          rz,
  input  logic          dec_v,
  output logic          dec_rdy,
  input  logic [RW-1:0] ra,
  input  logic [RW-1:0] rb,
  input  logic [RW-1:0] rc,
  input  logic [RW-1:0] rt,
  input  logic          ta,
  input  logic          tb,
  input  logic          tc,
  input  logic          tt,
  input  logic          rfwr,
  input  logic          vrfwr,
  input  logic          mc,
  input  logic          mem,
  input  logic          csr,
  output logic          iss_v,
  input  logic          iss_rdy,
  output logic [TW-1:0] iss_tag,
  input  logic          cmp_v,
  input  logic [TW-1:0] cmp_tag,
  output logic          busy,
  output logic [31:0]   stall_cnt
);

  logic [NREG-1:0] sb_s;
  logic [NREG-1:0] sb_v;
  tag_ent_t        tagtab [NTAG];
  logic            mem_busy;
  iss_state_e      state;

  logic            tag_free;
  logic [TW-1:0]   alloc_tag;
  logic            haz;
  logic            blocked;
  logic            accept;
  logic            alloc;
  logic            set_pend;
  logic            cmp_ok;
  tag_ent_t        cmp_ent;

  // Hazard check sees only registered pending bits.
  // A completion this cycle becomes visible from the next cycle.
  assign haz = reg_haz(ra, ta, rz, sb_s, sb_v)
             | reg_haz(rb, tb, rz, sb_s, sb_v)
             | reg_haz(rc, tc, rz, sb_s, sb_v)
             | ((rfwr | vrfwr) & reg_haz(rt, tt, rz, sb_s, sb_v));

  assign blocked = haz | (mc & ~tag_free) | (mem & mem_busy);

  // Ready is qualified with dec_v so an idle decode port sees ready low.
  assign dec_rdy = dec_v & (state == RUN) & ~blocked & (~iss_v | iss_rdy)
                 & (~csr | ~busy);

  // A flush cycle drops the instruction, so it allocates nothing.
  assign accept   = dec_rdy & ~flush;
  assign alloc    = accept & mc;
  assign set_pend = alloc & (rfwr | vrfwr) & ~(~tt & rz & (rt == '0));

  // Completions of tags that are not outstanding are ignored.
  // This also covers stragglers arriving after a reset.
  assign cmp_ent = tagtab[cmp_tag];
  assign cmp_ok  = cmp_v & cmp_ent.valid;

  rfphoenix_issue_ctrl_tag_pool u_tag_pool (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc     (alloc),
    .rel       (cmp_ok),
    .rel_tag   (cmp_tag),
    .avail     (tag_free),
    .alloc_tag (alloc_tag),
    .any_busy  (busy)
  );

  // Scoreboard and tag table.
  // The allocation update follows the completion update.
  // When both touch the same register in one cycle, the bit ends up set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_s     <= '0;
      sb_v     <= '0;
      mem_busy <= 1'b0;
      for (int i = 0; i < NTAG; i++)
        tagtab[i] <= '0;
    end else begin
      if (cmp_ok) begin
        if (cmp_ent.wr) begin
          if (cmp_ent.vec)
            sb_v[cmp_ent.idx] <= 1'b0;
          else
            sb_s[cmp_ent.idx] <= 1'b0;
        end
        if (cmp_ent.mem)
          mem_busy <= 1'b0;
        tagtab[cmp_tag].valid <= 1'b0;
      end
      if (alloc) begin
        tagtab[alloc_tag] <= '{valid: 1'b1, wr: set_pend, vec: tt, idx: rt, mem: mem};
        if (set_pend) begin
          if (tt)
            sb_v[rt] <= 1'b1;
          else
            sb_s[rt] <= 1'b1;
        end
        if (mem)
          mem_busy <= 1'b1;
      end
    end
  end

  // Sequencer state, issue stage and stall counter.
  // STALL and SERIAL each add one cycle after the blocking condition clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      iss_v     <= 1'b0;
      iss_tag   <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (dec_v && csr && busy)
              state <= SERIAL;
            else if (dec_v && blocked)
              state <= STALL;
          end
          STALL: begin
            if (!(dec_v && blocked))
              state <= RUN;
          end
          SERIAL: begin
            if (!busy)
              state <= RUN;
          end
          default: state <= RUN;
        endcase
      end

      if (flush) begin
        iss_v <= 1'b0;
      end else if (accept) begin
        iss_v   <= 1'b1;
        iss_tag <= mc ? alloc_tag : '0;
      end else if (iss_rdy) begin
        iss_v <= 1'b0;
      end

      if (dec_v && !dec_rdy && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_rfphoenix_issue_ctrl.sv
// Self-checking bench for rfphoenix_issue_ctrl.
// A per-cycle vector table covers the decode/issue/completion scenarios.
// Hand-written sequences cover flush and asynchronous reset.
module tb_rfphoenix_issue_ctrl;

  typedef enum logic [2:0] {K_NOP, K_ADD, K_FMA, K_LDW, K_STW, K_CSR} kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [5:0]  rt;
    logic        tt;
    logic [5:0]  ra;
    logic        ta;
    logic [5:0]  rb;
    logic        rz;
    logic        cmpv;
    logic [1:0]  cmpt;
    logic        e_rdy;
    logic        e_iss;
    logic        e_tagv;
    logic [1:0]  e_tag;
    logic        e_busy;
    logic        e_cntv;
    logic [31:0] e_cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        rz;
  logic        dec_v;
  logic        dec_rdy;
  logic [5:0]  ra, rb, rc, rt;
  logic        ta, tb, tc, tt;
  logic        rfwr, vrfwr, mc, mem, csr;
  logic        iss_v;
  logic        iss_rdy;
  logic [1:0]  iss_tag;
  logic        cmp_v;
  logic [1:0]  cmp_tag;
  logic        busy;
  logic [31:0] stall_cnt;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  rfphoenix_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rz        (rz),
    .dec_v     (dec_v),
    .dec_rdy   (dec_rdy),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .rt        (rt),
    .ta        (ta),
    .tb        (tb),
    .tc        (tc),
    .tt        (tt),
    .rfwr      (rfwr),
    .vrfwr     (vrfwr),
    .mc        (mc),
    .mem       (mem),
    .csr       (csr),
    .iss_v     (iss_v),
    .iss_rdy   (iss_rdy),
    .iss_tag   (iss_tag),
    .cmp_v     (cmp_v),
    .cmp_tag   (cmp_tag),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input kind_e k, input logic [5:0] dst, input logic dvec,
                               input logic [5:0] s1, input logic s1v, input logic [5:0] s2,
                               input logic zr, input logic cv, input logic [1:0] ct,
                               input logic fl, input logic ir);
    dec_v   = (k != K_NOP);
    rt      = dst;
    tt      = dvec;
    ra      = s1;
    ta      = s1v;
    rb      = s2;
    tb      = 1'b0;
    rc      = 6'd0;
    tc      = 1'b0;
    rfwr    = 1'b0;
    vrfwr   = 1'b0;
    mc      = 1'b0;
    mem     = 1'b0;
    csr     = 1'b0;
    case (k)
      K_ADD: rfwr = 1'b1;
      K_FMA: begin mc = 1'b1; rfwr = ~dvec; vrfwr = dvec; end
      K_LDW: begin mc = 1'b1; mem = 1'b1; rfwr = 1'b1; end
      K_STW: begin mc = 1'b1; mem = 1'b1; end
      K_CSR: csr = 1'b1;
      default: ;
    endcase
    rz      = zr;
    cmp_v   = cv;
    cmp_tag = ct;
    flush   = fl;
    iss_rdy = ir;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic row(input kind_e k, input int dst, input bit dvec, input int s1, input bit s1v,
                     input int s2, input bit zr, input bit cv, input int ct,
                     input bit erdy, input bit eiss, input int etag, input bit ebusy,
                     input int ecnt);
    vec_t v;
    v.kind   = k;
    v.rt     = 6'(dst);
    v.tt     = dvec;
    v.ra     = 6'(s1);
    v.ta     = s1v;
    v.rb     = 6'(s2);
    v.rz     = zr;
    v.cmpv   = cv;
    v.cmpt   = 2'(ct);
    v.e_rdy  = erdy;
    v.e_iss  = eiss;
    v.e_tagv = (etag >= 0);
    v.e_tag  = 2'(etag);
    v.e_busy = ebusy;
    v.e_cntv = (ecnt >= 0);
    v.e_cnt  = 32'(ecnt);
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;

    // Reset state
    rst_n = 1'b0;
    applyStimulus(K_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    #12;
    checkOutput("reset dec_rdy", 32'(dec_rdy), 32'd0);
    checkOutput("reset iss_v", 32'(iss_v), 32'd0);
    checkOutput("reset iss_tag", 32'(iss_tag), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Back-to-back single-cycle ADDs
    row(K_NOP, 0,0, 0,0,0, 1, 0,0,  0,0,-1,0, 0);
    row(K_ADD, 3,0, 1,0,2, 1, 0,0,  1,0,-1,0,-1);
    row(K_ADD, 3,0, 1,0,2, 1, 0,0,  1,1, 0,0,-1);
    row(K_ADD, 3,0, 1,0,2, 1, 0,0,  1,1, 0,0,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 0,0,  0,1, 0,0,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 0,0,  0,0,-1,0,-1);
    // FMA v5, then a RAW on v5, released one cycle after completion
    row(K_FMA, 5,1, 1,0,2, 1, 0,0,  1,0,-1,0,-1);
    row(K_ADD, 3,0, 5,1,2, 1, 0,0,  0,1, 0,1,-1);
    row(K_ADD, 3,0, 5,1,2, 1, 0,0,  0,0,-1,1,-1);
    row(K_ADD, 3,0, 5,1,2, 1, 1,0,  0,0,-1,1,-1);
    row(K_ADD, 3,0, 5,1,2, 1, 0,0,  0,0,-1,0,-1);
    row(K_ADD, 3,0, 5,1,2, 1, 0,0,  1,0,-1,0,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 0,0,  0,1, 0,0, 4);
    // Five FMAs: tags 0..3, fifth waits and then receives freed tag 2
    row(K_FMA,10,0, 1,0,2, 1, 0,0,  1,0,-1,0,-1);
    row(K_FMA,11,0, 1,0,2, 1, 0,0,  1,1, 0,1,-1);
    row(K_FMA,12,0, 1,0,2, 1, 0,0,  1,1, 1,1,-1);
    row(K_FMA,13,0, 1,0,2, 1, 0,0,  1,1, 2,1,-1);
    row(K_FMA,14,0, 1,0,2, 1, 0,0,  0,1, 3,1,-1);
    row(K_FMA,14,0, 1,0,2, 1, 1,2,  0,0,-1,1,-1);
    row(K_FMA,14,0, 1,0,2, 1, 0,0,  0,0,-1,1,-1);
    row(K_FMA,14,0, 1,0,2, 1, 0,0,  1,0,-1,1,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 1,0,  0,1, 2,1,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 1,1,  0,0,-1,1,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 1,2,  0,0,-1,1,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 1,3,  0,0,-1,1,-1);
    row(K_ADD, 3,0,12,0,14,1, 0,0,  1,0,-1,0, 7);
    row(K_NOP, 0,0, 0,0,0, 1, 0,0,  0,1, 0,0,-1);
    // Load outstanding blocks a store; CSR with two tags busy serialises
    row(K_LDW, 4,0, 1,0,2, 1, 0,0,  1,0,-1,0,-1);
    row(K_STW, 0,0, 6,0,7, 1, 0,0,  0,1, 0,1,-1);
    row(K_STW, 0,0, 6,0,7, 1, 1,0,  0,0,-1,1,-1);
    row(K_STW, 0,0, 6,0,7, 1, 0,0,  0,0,-1,0,-1);
    row(K_STW, 0,0, 6,0,7, 1, 0,0,  1,0,-1,0,-1);
    row(K_FMA,20,0, 1,0,2, 1, 0,0,  1,1, 0,1,-1);
    row(K_CSR, 0,0, 0,0,0, 1, 0,0,  0,1, 1,1,-1);
    row(K_CSR, 0,0, 0,0,0, 1, 1,0,  0,0,-1,1,-1);
    row(K_CSR, 0,0, 0,0,0, 1, 1,1,  0,0,-1,1,-1);
    row(K_CSR, 0,0, 0,0,0, 1, 0,0,  0,0,-1,0,-1);
    row(K_CSR, 0,0, 0,0,0, 1, 0,0,  1,0,-1,0,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 0,0,  0,1, 0,0,14);
    // r0 with rz=1 is never pending; with rz=0 it is tracked
    row(K_FMA, 0,0, 1,0,2, 1, 0,0,  1,0,-1,0,-1);
    row(K_ADD, 3,0, 0,0,0, 1, 0,0,  1,1, 0,1,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 1,0,  0,1, 0,1,-1);
    row(K_FMA, 0,0, 1,0,2, 0, 0,0,  1,0,-1,0,-1);
    row(K_ADD, 3,0, 0,0,1, 0, 0,0,  0,1, 0,1,-1);
    row(K_ADD, 3,0, 0,0,1, 0, 1,0,  0,0,-1,1,-1);
    row(K_ADD, 3,0, 0,0,1, 0, 0,0,  0,0,-1,0,-1);
    row(K_ADD, 3,0, 0,0,1, 0, 0,0,  1,0,-1,0,-1);
    row(K_NOP, 0,0, 0,0,0, 1, 0,0,  0,1, 0,0,17);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.kind, v.rt, v.tt, v.ra, v.ta, v.rb, v.rz, v.cmpv, v.cmpt, 1'b0, 1'b1);
      #2;
      checkOutput($sformatf("row%0d dec_rdy", i), 32'(dec_rdy), 32'(v.e_rdy));
      checkOutput($sformatf("row%0d iss_v", i), 32'(iss_v), 32'(v.e_iss));
      checkOutput($sformatf("row%0d busy", i), 32'(busy), 32'(v.e_busy));
      if (v.e_tagv)
        checkOutput($sformatf("row%0d iss_tag", i), 32'(iss_tag), 32'(v.e_tag));
      if (v.e_cntv)
        checkOutput($sformatf("row%0d stall_cnt", i), stall_cnt, v.e_cnt);
      tick();
    end

    // Flush drops the decode accepted in the same cycle, including its allocation
    applyStimulus(K_FMA, 8, 0, 1, 0, 2, 1, 0, 0, 1, 1);
    #2 checkOutput("flush cycle dec_rdy", 32'(dec_rdy), 32'd1);
    tick();
    applyStimulus(K_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    #2 checkOutput("flushed dec iss_v", 32'(iss_v), 32'd0);
    checkOutput("flushed dec busy", 32'(busy), 32'd0);
    tick();
    applyStimulus(K_ADD, 3, 0, 8, 0, 2, 1, 0, 0, 0, 1);
    #2 checkOutput("flushed dec no pending", 32'(dec_rdy), 32'd1);
    tick();
    // Flush of a held issue entry keeps its tag and pending bit
    applyStimulus(K_FMA, 8, 0, 1, 0, 2, 1, 0, 0, 0, 1);
    #2 checkOutput("fma r8 accept", 32'(dec_rdy), 32'd1);
    tick();
    applyStimulus(K_ADD, 9, 0, 1, 0, 2, 1, 0, 0, 0, 0);
    #2 checkOutput("backpressure dec_rdy", 32'(dec_rdy), 32'd0);
    checkOutput("backpressure iss_v", 32'(iss_v), 32'd1);
    checkOutput("backpressure iss_tag", 32'(iss_tag), 32'd0);
    tick();
    applyStimulus(K_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    #2 checkOutput("held entry before flush", 32'(iss_v), 32'd1);
    tick();
    applyStimulus(K_ADD, 3, 0, 8, 0, 2, 1, 0, 0, 1, 1);
    #2 checkOutput("flush clears iss_v", 32'(iss_v), 32'd0);
    checkOutput("flush keeps tag", 32'(busy), 32'd1);
    checkOutput("flush keeps pending", 32'(dec_rdy), 32'd0);
    tick();
    applyStimulus(K_NOP, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    tick();
    applyStimulus(K_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    #2 checkOutput("post-flush completion busy", 32'(busy), 32'd0);
    tick();

    // Async reset with three tags outstanding; a late completion is ignored
    applyStimulus(K_FMA, 30, 0, 1, 0, 2, 1, 0, 0, 0, 1);
    #2 checkOutput("rst seq fma0", 32'(dec_rdy), 32'd1);
    tick();
    applyStimulus(K_FMA, 31, 0, 1, 0, 2, 1, 0, 0, 0, 1);
    #2 checkOutput("rst seq fma1", 32'(dec_rdy), 32'd1);
    tick();
    applyStimulus(K_FMA, 32, 1, 1, 0, 2, 1, 0, 0, 0, 1);
    #2 checkOutput("rst seq fma2", 32'(dec_rdy), 32'd1);
    tick();
    applyStimulus(K_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    #2 checkOutput("rst seq busy before", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset iss_v", 32'(iss_v), 32'd0);
    checkOutput("mid reset iss_tag", 32'(iss_tag), 32'd0);
    checkOutput("mid reset stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(K_NOP, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1);
    #2 checkOutput("late cmp busy", 32'(busy), 32'd0);
    tick();
    applyStimulus(K_ADD, 3, 0, 31, 0, 30, 1, 0, 0, 0, 1);
    #2 checkOutput("late cmp ignored busy", 32'(busy), 32'd0);
    checkOutput("reset cleared scalar pending", 32'(dec_rdy), 32'd1);
    tick();
    applyStimulus(K_FMA, 32, 1, 1, 0, 2, 1, 0, 0, 0, 1);
    #2 checkOutput("reset cleared vector pending", 32'(dec_rdy), 32'd1);
    tick();
    applyStimulus(K_NOP, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    #2 checkOutput("post reset iss_v", 32'(iss_v), 32'd1);
    checkOutput("post reset first tag", 32'(iss_tag), 32'd0);
    checkOutput("post reset busy", 32'(busy), 32'd1);
    tick();
    applyStimulus(K_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    #2 checkOutput("post reset completion", 32'(busy), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
